serial_borrow_subtractor: RTL
=============================

// Module: serial_borrow_subtractor
// PURPOSE
//  Multi-cycle subtractor: computes DIFF = A - B - borrowin, CHUNK bits per clock, LSB first.
//  Inverse-direction companion to the adder datapath; a borrow register replaces the carry chain.
//  Sits behind a valid/ready operand port and presents a held result until it is consumed.
// PARAMETERS
//  NUMBITS  16  operand/result width; must be a multiple of CHUNK
//  CHUNK    1   bits processed per cycle (1..NUMBITS); latency = NUMBITS/CHUNK cycles
// PORTS
//  clk        in   1        single clock, rising edge
//  rst        in   1        synchronous, active-high reset
//  in_valid   in   1        operands A, B, borrowin valid
//  in_ready   out  1        block accepts operands this cycle
//  A          in   NUMBITS  minuend
//  B          in   NUMBITS  subtrahend
//  borrowin   in   1        borrow into bit 0
//  out_valid  out  1        difference/borrowout valid, held until accepted
//  out_ready  in   1        consumer takes result
//  difference out  NUMBITS  A - B - borrowin, mod 2^NUMBITS
//  borrowout  out  1        1 when A < B + borrowin (unsigned)
//  busy       out  1        high in RUN
// BEHAVIOUR
//  - Reset (rst=1 at clk edge): state=IDLE, in_ready=1, out_valid=0, busy=0,
//    difference=0, borrowout=0; internal operand/shift regs and chunk counter cleared.
//  - FSM IDLE -> RUN on in_valid&&in_ready: latch A, B; borrow reg <= borrowin; count <= 0.
//  - RUN: each cycle subtract low CHUNK bits of the A/B shift regs using the borrow reg;
//    shift result chunk into difference from the MSB end; borrow reg <= chunk borrow; count++.
//  - RUN -> DONE after chunk NUMBITS/CHUNK-1; borrowout <= final borrow; out_valid=1 in DONE.
//  - Latency: out_valid rises exactly NUMBITS/CHUNK cycles after the accept edge.
//  - DONE: difference/borrowout stable while out_valid && !out_ready.
//  - in_ready = (state==IDLE) || (state==DONE && out_ready); in_valid ignored in RUN.
//  - DONE with out_ready && in_valid same cycle: result retired and new operands accepted;
//    next state RUN (no IDLE bubble). DONE with out_ready only -> IDLE, out_valid=0.
//  - difference holds its last value in IDLE; only out_valid qualifies it.
//  - rst during RUN or DONE aborts: result discarded, reset values as above next cycle.
//  - Wrap-around: 0 - 1 -> all ones, borrowout=1; A==B with borrowin=1 -> all ones, borrowout=1.
//  - CHUNK==NUMBITS: single RUN cycle, latency 1.
// CONFIGURATION
//  SUB_OVERFLOW_EN defined: extra output port overflow (out, 1): two's-complement signed
//   overflow, = (A[MSB]!=B[MSB]) && (difference[MSB]!=A[MSB]), registered with borrowout,
//   reset 0, valid with out_valid. Requires latched A/B sign bits kept through RUN.
//  SUB_OVERFLOW_EN undefined: port and sign-bit registers absent; all else identical.
// STRUCTURE
//  Shared package: state encoding (IDLE=2'd0, RUN=2'd1, DONE=2'd2), count width
//   $clog2(NUMBITS/CHUNK) helper, default NUMBITS/CHUNK constants.
//  Sub-module: full_subtractor (1-bit: a, b, b_in -> d, b_out); CHUNK instances
//   chained by borrow inside a generate loop form the per-cycle chunk datapath.
//  Top holds FSM, counter, shift registers, handshake and output registers.
// TESTING
//  1 NUMBITS=16 CHUNK=1: A=16'h0005 B=16'h0003 bin=0 -> difference=16'h0002, borrowout=0,
//    out_valid exactly 16 cycles after accept.
//  2 A=16'h0000 B=16'h0001 bin=0 -> difference=16'hFFFF, borrowout=1; overflow=0 (EN build).
//  3 A=16'h8000 B=16'h0001 bin=0 -> difference=16'h7FFF, borrowout=0; overflow=1 (EN build).
//  4 A=16'h1234 B=16'h1234 bin=1 -> 16'hFFFF, borrowout=1; hold out_ready=0 for 5 cycles,
//    outputs stable, in_ready=0; then out_ready=1 with in_valid=1 -> new op accepted same edge.
//  5 Assert rst on cycle 7 of RUN -> next cycle out_valid=0, in_ready=1, difference=0;
//    following op A=16'h0010 B=16'h0008 -> 16'h0008 with correct latency.
//  6 CHUNK=4 and CHUNK=16 random sweep (>=1000 ops, random bin, random out_ready stalls)
//    vs golden {borrowout,difference} = {1'b0,A} - B - bin; latency 4 and 1 respectively.

Source files
------------

// File: rtl/serial_borrow_subtractor_pkg.sv
// Shared definitions for the serial borrow subtractor.
// Contents:
//   state_e    FSM state encoding (IDLE=0, RUN=1, DONE=2)
//   DefNumbits default operand width
//   DefChunk   default bits processed per cycle
//   cnt_width  width of the chunk counter for a given NUMBITS/CHUNK
package serial_borrow_subtractor_pkg;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StRun  = 2'd1,
    StDone = 2'd2
  } state_e;

  localparam int unsigned DefNumbits = 16;
  localparam int unsigned DefChunk   = 1;

  // A single-chunk configuration still needs a 1-bit counter.
  function automatic int unsigned cnt_width(input int unsigned numbits,
                                            input int unsigned chunk);
    int unsigned n;
    n = numbits / chunk;
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/serial_borrow_subtractor_full_subtractor.sv
// 1-bit full subtractor: d = a - b - b_in, with borrow out.
// Ports:
//   a, b   operand bits
//   b_in   borrow into this bit
//   d      difference bit
//   b_out  borrow out of this bit
module full_subtractor (
  input  logic a,
  input  logic b,
  input  logic b_in,
  output logic d,
  output logic b_out
);

  assign d     = a ^ b ^ b_in;
  // Borrow when a < b, or when a == b and a borrow is already pending.
  assign b_out = (~a & b) | (~(a ^ b) & b_in);

endmodule

// File: rtl/serial_borrow_subtractor.sv
// Multi-cycle subtractor: difference = A - B - borrowin, CHUNK bits per clock, LSB first.
// A borrow register threads the chunk borrow between cycles. Operands enter through a
// valid/ready port; the result is held in DONE until the consumer takes it.
// Optional feature macro: SUB_OVERFLOW_EN adds the 'overflow' output (signed overflow).
// Ports:
//   clk, rst             clock, synchronous active-high reset
//   in_valid / in_ready  operand handshake (A, B, borrowin)
//   out_valid/out_ready  result handshake (difference, borrowout[, overflow])
//   busy                 high while the datapath is running
module serial_borrow_subtractor
  import serial_borrow_subtractor_pkg::*;
#(
  parameter int unsigned NUMBITS = DefNumbits,
  parameter int unsigned CHUNK   = DefChunk
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [NUMBITS-1:0] A,
  input  logic [NUMBITS-1:0] B,
  input  logic               borrowin,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [NUMBITS-1:0] difference,
  output logic               borrowout,
`ifdef SUB_OVERFLOW_EN
  output logic               overflow,
`endif
  output logic               busy
);

  localparam int unsigned NumChunks = NUMBITS / CHUNK;
  localparam int unsigned CntW      = cnt_width(NUMBITS, CHUNK);
  localparam logic [CntW-1:0] LastCnt = CntW'(NumChunks - 1);

  state_e               state_q, state_d;
  logic [NUMBITS-1:0]   a_q, a_d, b_q, b_d;
  logic [NUMBITS-1:0]   diff_q, diff_d;
  logic                 borrow_q, borrow_d;
  logic                 bout_q, bout_d;
  logic [CntW-1:0]      cnt_q, cnt_d;

  logic [CHUNK-1:0]     chunk_diff;
  logic [CHUNK:0]       borrow_chain;
  logic                 accept;
  logic                 last_chunk;

`ifdef SUB_OVERFLOW_EN
  logic a_sign_q, a_sign_d, b_sign_q, b_sign_d;
  logic ovf_q, ovf_d;
`endif

  // Per-cycle chunk datapath: CHUNK full subtractors rippling the borrow.
  assign borrow_chain[0] = borrow_q;

  for (genvar gi = 0; gi < CHUNK; gi++) begin : g_chunk
    full_subtractor u_fs (
      .a    (a_q[gi]),
      .b    (b_q[gi]),
      .b_in (borrow_chain[gi]),
      .d    (chunk_diff[gi]),
      .b_out(borrow_chain[gi+1])
    );
  end

  assign in_ready   = (state_q == StIdle) || ((state_q == StDone) && out_ready);
  assign accept     = in_valid && in_ready;
  assign last_chunk = (state_q == StRun) && (cnt_q == LastCnt);

  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    diff_d   = diff_q;
    borrow_d = borrow_q;
    bout_d   = bout_q;
    cnt_d    = cnt_q;
`ifdef SUB_OVERFLOW_EN
    a_sign_d = a_sign_q;
    b_sign_d = b_sign_q;
    ovf_d    = ovf_q;
`endif

    unique case (state_q)
      StIdle:  if (accept) state_d = StRun;
      StRun:   if (last_chunk) state_d = StDone;
      // Retire and reload on the same edge avoids an IDLE bubble.
      StDone:  if (out_ready) state_d = in_valid ? StRun : StIdle;
      default: state_d = StIdle;
    endcase

    if (accept) begin
      a_d      = A;
      b_d      = B;
      borrow_d = borrowin;
      cnt_d    = '0;
`ifdef SUB_OVERFLOW_EN
      a_sign_d = A[NUMBITS-1];
      b_sign_d = B[NUMBITS-1];
`endif
    end else if (state_q == StRun) begin
      a_d      = a_q >> CHUNK;
      b_d      = b_q >> CHUNK;
      // New chunk enters at the MSB end; after NumChunks shifts it is fully aligned.
      diff_d   = NUMBITS'({chunk_diff, diff_q} >> CHUNK);
      borrow_d = borrow_chain[CHUNK];
      cnt_d    = cnt_q + 1'b1;
      if (last_chunk) begin
        bout_d = borrow_chain[CHUNK];
`ifdef SUB_OVERFLOW_EN
        // chunk_diff MSB is the final difference sign bit.
        ovf_d  = (a_sign_q != b_sign_q) && (chunk_diff[CHUNK-1] != a_sign_q);
`endif
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StIdle;
      a_q      <= '0;
      b_q      <= '0;
      diff_q   <= '0;
      borrow_q <= 1'b0;
      bout_q   <= 1'b0;
      cnt_q    <= '0;
`ifdef SUB_OVERFLOW_EN
      a_sign_q <= 1'b0;
      b_sign_q <= 1'b0;
      ovf_q    <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      diff_q   <= diff_d;
      borrow_q <= borrow_d;
      bout_q   <= bout_d;
      cnt_q    <= cnt_d;
`ifdef SUB_OVERFLOW_EN
      a_sign_q <= a_sign_d;
      b_sign_q <= b_sign_d;
      ovf_q    <= ovf_d;
`endif
    end
  end

  assign out_valid  = (state_q == StDone);
  assign busy       = (state_q == StRun);
  assign difference = diff_q;
  assign borrowout  = bout_q;
`ifdef SUB_OVERFLOW_EN
  assign overflow   = ovf_q;
`endif

endmodule
